// File: rtl/spr_cmd_arbiter.sv
// Round-robin arbiter between two requesters sharing one single-port RAM command port.
// Each accepted op becomes an address word (unless the shadow address matches) plus a data/go word.
module spr_cmd_arbiter #(
    parameter int ADDR_SIZE  = 8,
    parameter int ADDR_SKIP  = 1,
    parameter int TO_W       = 4,
    parameter int RD_TIMEOUT = 15
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req0_valid,
    input  logic                 req0_rw,
    input  logic [ADDR_SIZE-1:0] req0_addr,
    input  logic [7:0]           req0_wdata,
    output logic                 req0_ready,
    output logic                 rsp0_valid,
    output logic [7:0]           rsp0_rdata,
    output logic                 rsp0_err,
    input  logic                 req1_valid,
    input  logic                 req1_rw,
    input  logic [ADDR_SIZE-1:0] req1_addr,
    input  logic [7:0]           req1_wdata,
    output logic                 req1_ready,
    output logic                 rsp1_valid,
    output logic [7:0]           rsp1_rdata,
    output logic                 rsp1_err,
    output logic                 ram_rx_valid,
    output logic [9:0]           ram_din,
    input  logic                 ram_tx_valid,
    input  logic [7:0]           ram_dout
);

    typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_RD_WAIT} state_t;

    localparam logic [TO_W-1:0] TO_LAST = TO_W'(RD_TIMEOUT - 1);
    localparam bit SKIP = (ADDR_SKIP != 0);

    state_t                 state_q, state_d;
    logic                   last_gnt_q, last_gnt_d;
    logic                   op_rw_q, op_rw_d;
    logic                   op_id_q, op_id_d;
    logic [ADDR_SIZE-1:0]   op_addr_q, op_addr_d;
    logic [7:0]             op_wdata_q, op_wdata_d;
    logic                   wr_sh_valid_q, wr_sh_valid_d;
    logic                   rd_sh_valid_q, rd_sh_valid_d;
    logic [ADDR_SIZE-1:0]   wr_sh_addr_q, wr_sh_addr_d;
    logic [ADDR_SIZE-1:0]   rd_sh_addr_q, rd_sh_addr_d;
    logic [TO_W-1:0]        timer_q, timer_d;
    logic [1:0]             rsp_valid_q, rsp_valid_d;
    logic [1:0]             rsp_err_q, rsp_err_d;
    logic [1:0][7:0]        rsp_rdata_q, rsp_rdata_d;

    logic [1:0]             ready_c;
    logic                   gnt_id;
    logic                   sel_rw;
    logic [ADDR_SIZE-1:0]   sel_addr;
    logic                   sel_hit;

    always_comb begin
        state_d       = state_q;
        last_gnt_d    = last_gnt_q;
        op_rw_d       = op_rw_q;
        op_id_d       = op_id_q;
        op_addr_d     = op_addr_q;
        op_wdata_d    = op_wdata_q;
        wr_sh_valid_d = wr_sh_valid_q;
        rd_sh_valid_d = rd_sh_valid_q;
        wr_sh_addr_d  = wr_sh_addr_q;
        rd_sh_addr_d  = rd_sh_addr_q;
        timer_d       = timer_q;
        rsp_valid_d   = 2'b00;
        rsp_err_d     = rsp_err_q;
        rsp_rdata_d   = rsp_rdata_q;
        ready_c       = 2'b00;
        ram_rx_valid  = 1'b0;
        ram_din       = 10'h000;

        // On a tie the requester that did not win last time gets the grant.
        gnt_id   = (req0_valid && req1_valid) ? ~last_gnt_q : req1_valid;
        sel_rw   = gnt_id ? req1_rw   : req0_rw;
        sel_addr = gnt_id ? req1_addr : req0_addr;
        sel_hit  = sel_rw ? (wr_sh_valid_q && (wr_sh_addr_q == sel_addr))
                          : (rd_sh_valid_q && (rd_sh_addr_q == sel_addr));

        case (state_q)
            S_IDLE: begin
                if (req0_valid || req1_valid) begin
                    ready_c[gnt_id] = 1'b1;
                    last_gnt_d      = gnt_id;
                    op_id_d         = gnt_id;
                    op_rw_d         = sel_rw;
                    op_addr_d       = sel_addr;
                    op_wdata_d      = gnt_id ? req1_wdata : req0_wdata;
                    state_d         = (SKIP && sel_hit) ? S_DATA : S_ADDR;
                end
            end
            S_ADDR: begin
                ram_rx_valid = 1'b1;
                ram_din      = {(op_rw_q ? 2'b00 : 2'b10), op_addr_q};
                if (op_rw_q) begin
                    wr_sh_valid_d = 1'b1;
                    wr_sh_addr_d  = op_addr_q;
                end else begin
                    rd_sh_valid_d = 1'b1;
                    rd_sh_addr_d  = op_addr_q;
                end
                state_d = S_DATA;
            end
            S_DATA: begin
                ram_rx_valid = 1'b1;
                ram_din      = op_rw_q ? {2'b01, op_wdata_q} : {2'b11, 8'h00};
                timer_d      = '0;
                state_d      = op_rw_q ? S_IDLE : S_RD_WAIT;
            end
            S_RD_WAIT: begin
                if (ram_tx_valid) begin
                    rsp_valid_d[op_id_q] = 1'b1;
                    rsp_err_d[op_id_q]   = 1'b0;
                    rsp_rdata_d[op_id_q] = ram_dout;
                    state_d              = S_IDLE;
                end else if (timer_q == TO_LAST) begin
                    // RAM state is unknown after an abort, so force both address words to be resent.
                    rsp_valid_d[op_id_q] = 1'b1;
                    rsp_err_d[op_id_q]   = 1'b1;
                    rsp_rdata_d[op_id_q] = 8'h00;
                    wr_sh_valid_d        = 1'b0;
                    rd_sh_valid_d        = 1'b0;
                    state_d              = S_IDLE;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            last_gnt_q    <= 1'b1;
            op_rw_q       <= 1'b0;
            op_id_q       <= 1'b0;
            op_addr_q     <= '0;
            op_wdata_q    <= 8'h00;
            wr_sh_valid_q <= 1'b0;
            rd_sh_valid_q <= 1'b0;
            wr_sh_addr_q  <= '0;
            rd_sh_addr_q  <= '0;
            timer_q       <= '0;
            rsp_valid_q   <= 2'b00;
            rsp_err_q     <= 2'b00;
            rsp_rdata_q   <= '0;
        end else begin
            state_q       <= state_d;
            last_gnt_q    <= last_gnt_d;
            op_rw_q       <= op_rw_d;
            op_id_q       <= op_id_d;
            op_addr_q     <= op_addr_d;
            op_wdata_q    <= op_wdata_d;
            wr_sh_valid_q <= wr_sh_valid_d;
            rd_sh_valid_q <= rd_sh_valid_d;
            wr_sh_addr_q  <= wr_sh_addr_d;
            rd_sh_addr_q  <= rd_sh_addr_d;
            timer_q       <= timer_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_err_q     <= rsp_err_d;
            rsp_rdata_q   <= rsp_rdata_d;
        end
    end

    assign req0_ready = ready_c[0] & ~rst;
    assign req1_ready = ready_c[1] & ~rst;
    assign rsp0_valid = rsp_valid_q[0];
    assign rsp1_valid = rsp_valid_q[1];
    assign rsp0_err   = rsp_err_q[0];
    assign rsp1_err   = rsp_err_q[1];
    assign rsp0_rdata = rsp_rdata_q[0];
    assign rsp1_rdata = rsp_rdata_q[1];

endmodule
